// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS front end.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } memstate_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_ir_mem_unit_pc_next_mux.sv
// Next-PC selection: ALU result, registered ALU result, or pseudo-direct jump target.
module pc_next_mux
   import mips_pkg::*;
(
   input  logic        pcsrc,
   input  logic        jump,
   input  logic [31:0] aluresult,
   input  logic [31:0] aluout,
   input  logic [25:0] instr_idx,
   input  logic [3:0]  pc_hi,
   output logic [31:0] next_pc
);

   always_comb begin
      next_pc = pcsrc ? aluout : aluresult;
      if (jump) next_pc = {pc_hi, instr_idx, 2'b00};
   end

endmodule

// File: rtl/pc_ir_mem_unit.sv
// PC/IR/MDR owner and req/ready memory sequencer; stalls the main decoder during accesses.
module pc_ir_mem_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pcwrite,
   input  logic        branch,
   input  logic        zero,
   input  logic        pcsrc,
   input  logic        jump,
   input  logic        iord,
   input  logic        irwrite,
   input  logic        memwrite,
   input  logic        memread,
   input  logic [31:0] aluresult,
   input  logic [31:0] aluout,
   input  logic [31:0] wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic [31:0] data,
   output logic        stall,
   output logic        err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   memstate_t      state, state_nxt;
   logic [CW-1:0]  cnt;
   logic           acc;
   logic           illegal;
   logic           pcen;
   logic           timed_out;
   logic           sel_ir;
   logic           sel_mdr;
   logic [31:0]    next_pc;

   assign acc       = irwrite | memread | memwrite;
   assign illegal   = (irwrite & memread) | (irwrite & memwrite) | (memread & memwrite);
   assign pcen      = pcwrite | (branch & zero);
   assign timed_out = (cnt == CW'(TIMEOUT - 1));
   assign stall     = acc & (state != DONE);

   pc_next_mux u_pc_next_mux (
      .pcsrc     (pcsrc),
      .jump      (jump),
      .aluresult (aluresult),
      .aluout    (aluout),
      .instr_idx (instr[25:0]),
      .pc_hi     (pc[31:28]),
      .next_pc   (next_pc)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (acc) state_nxt = BUSY;
         BUSY:    if (mem_ready || timed_out) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         pc        <= RESET_PC;
         instr     <= '0;
         data      <= '0;
         err       <= 1'b0;
         sel_ir    <= 1'b0;
         sel_mdr   <= 1'b0;
      end else begin
         state <= state_nxt;
         // PC+4 of a fetch lands in DONE, after the fetch address was already latched
         if (pcen && !stall) pc <= next_pc;
         if (acc && illegal) err <= 1'b1;
         case (state)
            IDLE: begin
               if (acc) begin
                  mem_addr  <= iord ? aluout : pc;
                  mem_we    <= memwrite & ~irwrite & ~memread;
                  mem_wdata <= wdata;
                  mem_req   <= 1'b1;
                  cnt       <= '0;
                  sel_ir    <= irwrite;
                  sel_mdr   <= memread & ~irwrite;
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  if (sel_ir)  instr <= mem_rdata;
                  if (sel_mdr) data  <= mem_rdata;
                  mem_req <= 1'b0;
               end else if (timed_out) begin
                  mem_req <= 1'b0;
                  err     <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_ir_mem_unit.sv
// Directed bench for pc_ir_mem_unit with a transaction-level expectation model.
module tb_pc_ir_mem_unit;
   import mips_pkg::*;

   localparam int TO = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic        pcwrite, branch, zero, pcsrc, jump, iord, irwrite, memwrite, memread;
   logic [31:0] aluresult, aluout, wdata, mem_rdata;
   logic        mem_ready;
   logic        mem_req, mem_we, stall, err;
   logic [31:0] mem_addr, mem_wdata, pc, instr, data;

   int total = 0;
   int bad   = 0;

   logic [31:0] e_pc, e_instr, e_data, e_addr, e_wd;
   bit          e_err, e_stall, e_req, e_we, bus_chk;

   always #5 clk = ~clk;

   pc_ir_mem_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .pcwrite(pcwrite), .branch(branch), .zero(zero),
      .pcsrc(pcsrc), .jump(jump), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
      .memread(memread), .aluresult(aluresult), .aluout(aluout), .wdata(wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc), .instr(instr), .data(data),
      .stall(stall), .err(err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("pc", pc, e_pc);
      chk("instr", instr, e_instr);
      chk("data", data, e_data);
      chk("err", 32'(err), 32'(e_err));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      if (bus_chk) begin
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_we", 32'(mem_we), 32'(e_we));
         chk("mem_wdata", mem_wdata, e_wd);
      end
   endtask

   // Check the current cycle away from the edge, then advance past the next edge.
   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ctrl();
      pcwrite = 0; branch = 0; zero = 0; pcsrc = 0; jump = 0;
      iord = 0; irwrite = 0; memwrite = 0; memread = 0;
      mem_ready = 0;
   endtask

   task automatic access(input bit ir, input bit mr, input bit mw, input bit io, input bit pw,
                         input logic [31:0] alures, input logic [31:0] aluo,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits);
      logic [31:0] a;
      bit          ill, to;
      int          nb;
      a   = io ? aluo : e_pc;
      ill = (int'(ir) + int'(mr) + int'(mw)) > 1;
      to  = waits >= TO;
      nb  = to ? TO : waits + 1;
      irwrite = ir; memread = mr; memwrite = mw; iord = io; pcwrite = pw;
      branch = 0; zero = 0; pcsrc = 0; jump = 0;
      aluresult = alures; aluout = aluo; wdata = wd;
      mem_ready = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      e_stall = 1; e_req = 0; bus_chk = 0;
      step();
      if (ill) e_err = 1;
      for (int i = 0; i < nb; i++) begin
         mem_ready = (i == waits);
         mem_rdata = (i == waits) ? rd : 32'hBAD0_0000 + 32'(i);
         e_stall = 1; e_req = 1; bus_chk = 1;
         e_addr = a; e_we = mw & ~ir & ~mr; e_wd = wd;
         step();
      end
      mem_ready = 0;
      e_stall = 0; e_req = 0; bus_chk = 0;
      if (to)      e_err   = 1;
      else if (ir) e_instr = rd;
      else if (mr) e_data  = rd;
      step();
      if (pw) e_pc = alures;
      idle_ctrl();
   endtask

   task automatic pcupd(input bit pw, input bit br, input bit z, input bit ps, input bit jp,
                        input logic [31:0] alures, input logic [31:0] aluo);
      idle_ctrl();
      pcwrite = pw; branch = br; zero = z; pcsrc = ps; jump = jp;
      aluresult = alures; aluout = aluo;
      e_stall = 0; e_req = 0; bus_chk = 0;
      step();
      if (pw | (br & z))
         e_pc = jp ? {e_pc[31:28], e_instr[25:0], 2'b00} : (ps ? aluo : alures);
      idle_ctrl();
   endtask

   task automatic reset_vals();
      e_pc = 32'h0; e_instr = 32'h0; e_data = 32'h0; e_err = 0;
      e_stall = 0; e_req = 0;
      bus_chk = 1; e_addr = 32'h0; e_we = 0; e_wd = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [31:0] w_lw, w_j, w_ill;
      w_lw  = {OP_LW, 5'd0, 5'd8, 16'h0004};
      w_j   = {OP_J, 26'h10};
      w_ill = 32'h2010_0007;
      idle_ctrl();
      aluresult = 0; aluout = 0; wdata = 0; mem_rdata = 0;
      reset = 0;
      @(posedge clk); #1;
      reset_vals();
      step();
      reset = 1;
      step();
      bus_chk = 0;

      // fetch, zero wait
      access(1, 0, 0, 0, 1, e_pc + 32'd4, 32'h0, 32'h0, w_lw, 0);
      chk("fetch_instr_lit", instr, 32'h8C08_0004);
      chk("fetch_pc_lit", pc, 32'h0000_0004);

      // store with 3 wait states, ready also offered in IDLE
      access(0, 0, 1, 1, 0, 32'h0, 32'h40, 32'hDEAD_BEEF, 32'h0, 3);
      // load accepted on the last allowed BUSY cycle
      access(0, 1, 0, 1, 0, 32'h0, 32'h44, 32'h0, 32'h1234_5678, TO - 1);
      chk("load_data_lit", data, 32'h1234_5678);
      // load that times out
      access(0, 1, 0, 1, 0, 32'h0, 32'h48, 32'h0, 32'hCAFE_0000, TO);
      chk("timeout_err_lit", 32'(err), 32'h1);
      chk("timeout_data_lit", data, 32'h1234_5678);
      step();

      // reset held two cycles in the middle of a fetch
      irwrite = 1; pcwrite = 1; iord = 0; aluresult = e_pc + 32'd4; wdata = 32'h5555_AAAA;
      e_stall = 1; e_req = 0; bus_chk = 0;
      step();
      for (int i = 0; i < 2; i++) begin
         e_req = 1; bus_chk = 1; e_addr = e_pc; e_we = 0; e_wd = 32'h5555_AAAA;
         step();
      end
      idle_ctrl();
      reset = 0;
      e_stall = 0;
      step();
      reset_vals();
      step();
      reset = 1;
      mem_ready = 1;
      step();
      chk("rst_req_lit", 32'(mem_req), 32'h0);
      chk("rst_pc_lit", pc, 32'h0);
      mem_ready = 0;
      bus_chk = 0;

      // fetch a jump word, then branch/jump updates
      access(1, 0, 0, 0, 1, e_pc + 32'd4, 32'h0, 32'h0, w_j, 1);
      pcupd(0, 1, 0, 1, 0, 32'h999, 32'h200);
      pcupd(0, 1, 1, 1, 0, 32'h999, 32'h100);
      chk("branch_pc_lit", pc, 32'h0000_0100);
      pcupd(1, 0, 0, 0, 0, 32'hA000_0000, 32'h0);
      pcupd(1, 0, 0, 1, 1, 32'h777, 32'h300);
      chk("jump_pc_lit", pc, 32'hA000_0040);

      // illegal irwrite+memwrite
      access(1, 0, 1, 0, 1, e_pc + 32'd4, 32'h0, 32'h1111_2222, w_ill, 2);
      chk("illegal_err_lit", 32'(err), 32'h1);
      chk("illegal_instr_lit", instr, 32'h2010_0007);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
